halt_dump_ctrl: RTL and testbench
=================================

Name: halt_dump_ctrl

Overview:
Post-halt sequencer for the 16-bit CPU core.
- Watches the fetched instruction for either halt encoding.
- Lets the pipeline drain for a fixed number of cycles.
- Reads out all 16 architectural registers, then scans the 64K x 16 data memory through its read port.
- Streams (kind, address, data) records over a valid/ready interface to a trace/dump sink.
- Sits beside the cpu top level and owns the debug read ports of the register file and data memory once the core has halted.

Parameters:
DRAIN_CYCLES, 10, cycles waited after halt detection before the first read
NUM_REGS, 16, register-file entries dumped (indices 0..NUM_REGS-1)
MEM_DEPTH, 65536, data-memory words scanned (addresses 0..MEM_DEPTH-1)
SKIP_ZERO, 1, when 1 memory words equal to 16'h0000 are not emitted; registers are always emitted

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
instr  in  16  instruction currently fetched by the core
reg_rd_idx  out  4  register-file debug read index (combinational read)
reg_rd_data  in  16  register-file debug read data, same cycle
mem_rd_en  out  1  data-memory debug read strobe
mem_rd_addr  out  16  data-memory debug read address
mem_rd_data  in  16  read data, valid the cycle after mem_rd_en (synchronous read)
out_valid  out  1  dump record valid
out_ready  in  1  sink accepts record
out_kind  out  1  0 = register record, 1 = memory record
out_addr  out  16  register index (zero-extended) or memory address
out_data  out  16  register or memory contents
halted  out  1  sticky: halt instruction seen
done  out  1  sticky: dump complete

Behaviour:
- Halt encodings: instr == 16'hE000 or instr == 16'hE7FF. Any other value, including X-free lookalikes, is ignored.
- Reset, applied in any state, puts the block in IDLE and drives every output to 0. This includes out_valid, mem_rd_en, halted and done. Counters clear. A dump in progress is abandoned and not resumed.
- FSM states: IDLE, DRAIN, REG, MEM_RD, MEM_CHK, MEM_OUT, DONE.
- IDLE: halt match -> DRAIN; halted=1 from the next cycle. drain_cnt loads 0.
- DRAIN: drain_cnt increments each cycle. When drain_cnt == DRAIN_CYCLES-1 -> REG with reg_idx=0. The first REG cycle is exactly DRAIN_CYCLES+1 cycles after the halt-match edge. instr is ignored in every state other than IDLE.
- REG:
  - reg_rd_idx=reg_idx; out_valid=1, out_kind=0, out_addr={12'b0,reg_idx}, out_data=reg_rd_data.
  - On out_valid&&out_ready: if reg_idx==NUM_REGS-1 -> MEM_RD with mem_addr=0; else reg_idx++.
  - Output is held stable while out_ready=0.
- MEM_RD: mem_rd_en=1 for exactly one cycle, mem_rd_addr=mem_addr -> MEM_CHK.
- MEM_CHK: capture mem_rd_data into data_q.
  - If SKIP_ZERO && data==0: if mem_addr==MEM_DEPTH-1 -> DONE, else mem_addr++ -> MEM_RD.
  - Otherwise -> MEM_OUT.
- MEM_OUT: out_valid=1, out_kind=1, out_addr=mem_addr, out_data=data_q, all held stable until accepted. On acceptance, last address -> DONE, else mem_addr++ -> MEM_RD.
- Once out_valid is asserted it never deasserts until the record is accepted. out_* values are don't-care while out_valid=0 but are driven to 0.
- mem_addr is 17 bits internally so that MEM_DEPTH=65536 terminates without wrap. The 16-bit port carries the low bits and never wraps back to 0 within a scan.
- DONE: done=1, out_valid=0, mem_rd_en=0. Stays here until reset. A further halt match in DONE is ignored.
- Throughput:
  - Registers: one record per cycle when out_ready is held high.
  - Memory: non-zero word = 3 cycles per record minimum (MEM_RD, MEM_CHK, MEM_OUT); skipped word = 2 cycles.
- mem_rd_en is never asserted outside MEM_RD, so the core's own memory port is untouched before halt.

Decomposition:
- Shared package cpu_pkg:
  - HALT_OP_A=16'hE000, HALT_OP_B=16'hE7FF.
  - typedef dump_kind_e {DUMP_REG=1'b0, DUMP_MEM=1'b1}.
  - typedef word_t = logic[15:0].
  - The FSM state enum stays local to the module.
- One sub-module is natural: halt_detect. It does the combinational compare of instr against both halt opcodes and gates it with the IDLE state. Everything else lives in a single module.

Test Plan:
- Halt timing: instr=16'h1234 for 5 cycles, then 16'hE000 for 1 cycle, DRAIN_CYCLES=10 -> halted rises the next cycle; first out_valid with out_kind=0, out_addr=0 occurs exactly 11 cycles after the halt edge; mem_rd_en stays 0 throughout.
- Register dump: reg model returns 16'hA000+idx, out_ready=1 -> 16 consecutive records (0,A000)..(15,A00F) on 16 consecutive cycles, then the first mem_rd_en.
- Memory skip: SKIP_ZERO=1, memory zero except mem[5]=16'h00FF and mem[65535]=16'hBEEF -> exactly two memory records, (5,00FF) and (65535,BEEF), then done=1 with no address wrap to 0.
- Backpressure: out_ready=0 for 7 cycles while the record for mem[5] is presented -> out_valid, out_addr=5 and out_data=00FF held stable; no further mem_rd_en until acceptance.
- Second encoding and reset mid-dump: halt with 16'hE7FF, assert reset during MEM phase at mem_addr=100 -> next cycle all outputs are 0, halted=0, done=0; a new 16'hE000 restarts the full sequence from register 0.
- No skip: SKIP_ZERO=1 then SKIP_ZERO=0 on a small MEM_DEPTH=4 build with all-zero memory -> 0 memory records vs 4 records (0..3, data 0), both ending with done=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-level types and constants used by the post-halt dump logic.
package cpu_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic {
    DUMP_REG = 1'b0,
    DUMP_MEM = 1'b1
  } dump_kind_e;

  localparam word_t HALT_OP_A = 16'hE000;
  localparam word_t HALT_OP_B = 16'hE7FF;

  function automatic logic is_halt_op(input word_t op);
    return (op == HALT_OP_A) || (op == HALT_OP_B);
  endfunction

endpackage

// File: rtl/halt_dump_ctrl_if.sv
// Valid/ready record stream from the dump sequencer to the trace/dump sink.
interface halt_dump_ctrl_if;
  import cpu_pkg::*;

  logic       out_valid;
  logic       out_ready;
  dump_kind_e out_kind;
  word_t      out_addr;
  word_t      out_data;

  modport master (output out_valid, out_kind, out_addr, out_data, input out_ready);
  modport slave  (input out_valid, out_kind, out_addr, out_data, output out_ready);

endinterface

// File: rtl/halt_dump_ctrl_halt_detect.sv
// Combinational halt-opcode match, only meaningful while the sequencer is idle.
module halt_detect
  import cpu_pkg::*;
(
  input  word_t instr,
  input  logic  idle,
  output logic  hit
);

  assign hit = idle && is_halt_op(instr);

endmodule

// File: rtl/halt_dump_ctrl.sv
// Post-halt sequencer: drains the pipeline, then streams register and data-memory contents.
module halt_dump_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 10,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned MEM_DEPTH    = 65536,
  parameter bit          SKIP_ZERO    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  word_t            instr,
  output logic [3:0]       reg_rd_idx,
  input  word_t            reg_rd_data,
  output logic             mem_rd_en,
  output word_t            mem_rd_addr,
  input  word_t            mem_rd_data,
  halt_dump_ctrl_if.master dump,
  output logic             halted,
  output logic             done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRAIN   = 3'd1;
  localparam logic [2:0] S_REG     = 3'd2;
  localparam logic [2:0] S_MEM_RD  = 3'd3;
  localparam logic [2:0] S_MEM_CHK = 3'd4;
  localparam logic [2:0] S_MEM_OUT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [3:0]  REG_LAST   = 4'(NUM_REGS - 1);
  localparam logic [16:0] MEM_LAST   = 17'(MEM_DEPTH - 1);

  logic [2:0]  state;
  logic [15:0] drain_cnt;
  logic [3:0]  reg_idx;
  // One bit wider than the port so a full 64K scan ends without wrapping.
  logic [16:0] mem_addr;
  word_t       data_q;
  logic        idle;
  logic        halt_hit;

  assign idle = (state == S_IDLE);

  halt_detect u_halt_detect (
    .instr (instr),
    .idle  (idle),
    .hit   (halt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      reg_idx   <= '0;
      mem_addr  <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (halt_hit) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 16'd1;
          if (drain_cnt == DRAIN_LAST) begin
            state   <= S_REG;
            reg_idx <= '0;
          end
        end
        S_REG: begin
          if (dump.out_ready) begin
            if (reg_idx == REG_LAST) begin
              state    <= S_MEM_RD;
              mem_addr <= '0;
            end else begin
              reg_idx <= reg_idx + 4'd1;
            end
          end
        end
        S_MEM_RD: state <= S_MEM_CHK;
        S_MEM_CHK: begin
          data_q <= mem_rd_data;
          if (SKIP_ZERO && (mem_rd_data == '0)) begin
            if (mem_addr == MEM_LAST) begin
              state <= S_DONE;
            end else begin
              mem_addr <= mem_addr + 17'd1;
              state    <= S_MEM_RD;
            end
          end else begin
            state <= S_MEM_OUT;
          end
        end
        S_MEM_OUT: begin
          if (dump.out_ready) begin
            if (mem_addr == MEM_LAST) begin
              state <= S_DONE;
            end else begin
              mem_addr <= mem_addr + 17'd1;
              state    <= S_MEM_RD;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_rd_idx     = '0;
    mem_rd_en      = 1'b0;
    mem_rd_addr    = '0;
    dump.out_valid = 1'b0;
    dump.out_kind  = DUMP_REG;
    dump.out_addr  = '0;
    dump.out_data  = '0;
    case (state)
      S_REG: begin
        reg_rd_idx     = reg_idx;
        dump.out_valid = 1'b1;
        dump.out_kind  = DUMP_REG;
        dump.out_addr  = {12'b0, reg_idx};
        dump.out_data  = reg_rd_data;
      end
      S_MEM_RD: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = mem_addr[15:0];
      end
      S_MEM_OUT: begin
        dump.out_valid = 1'b1;
        dump.out_kind  = DUMP_MEM;
        dump.out_addr  = mem_addr[15:0];
        dump.out_data  = data_q;
      end
      default: ;
    endcase
  end

  assign halted = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Self-checking bench for halt_dump_ctrl: halt timing, register/memory dump, backpressure, reset, skip modes.
module tb_halt_dump_ctrl;
  import cpu_pkg::*;

  localparam int unsigned DEPTH_A = 4096;
  localparam word_t       LAST_A  = 16'(DEPTH_A - 1);

  typedef struct packed {
    logic  kind;
    word_t addr;
    word_t data;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  rec_t sb[$];

  // Main DUT: 4096-word memory with two non-zero words.
  logic       reset_a;
  word_t      instr_a;
  logic [3:0] ridx_a;
  word_t      rdata_a;
  logic       mem_en_a;
  word_t      maddr_a;
  word_t      mdata_a;
  logic       halted_a, done_a;
  halt_dump_ctrl_if ifa ();

  halt_dump_ctrl #(.DRAIN_CYCLES(10), .NUM_REGS(16), .MEM_DEPTH(DEPTH_A), .SKIP_ZERO(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .instr(instr_a), .reg_rd_idx(ridx_a), .reg_rd_data(rdata_a),
    .mem_rd_en(mem_en_a), .mem_rd_addr(maddr_a), .mem_rd_data(mdata_a), .dump(ifa),
    .halted(halted_a), .done(done_a)
  );

  function automatic word_t mem_a_model(input word_t a);
    if (a == 16'd5)   return 16'h00FF;
    if (a == LAST_A)  return 16'hBEEF;
    return 16'h0000;
  endfunction

  assign rdata_a = 16'hA000 + {12'b0, ridx_a};
  always @(posedge clk) if (mem_en_a) mdata_a <= mem_a_model(maddr_a);

  // Small 4-word all-zero DUTs: B skips zero words, C emits them.
  logic       reset_s;
  word_t      instr_s;
  word_t      zero_w = 16'h0000;
  logic [3:0] ridx_b, ridx_c;
  word_t      rdata_b, rdata_c;
  logic       mem_en_b, mem_en_c;
  word_t      maddr_b, maddr_c;
  logic       halted_b, halted_c, done_b, done_c;
  halt_dump_ctrl_if ifb ();
  halt_dump_ctrl_if ifc ();

  assign rdata_b = 16'h5A00 + {12'b0, ridx_b};
  assign rdata_c = 16'h5A00 + {12'b0, ridx_c};

  halt_dump_ctrl #(.DRAIN_CYCLES(10), .NUM_REGS(16), .MEM_DEPTH(4), .SKIP_ZERO(1'b1)) dut_b (
    .clk(clk), .reset(reset_s), .instr(instr_s), .reg_rd_idx(ridx_b), .reg_rd_data(rdata_b),
    .mem_rd_en(mem_en_b), .mem_rd_addr(maddr_b), .mem_rd_data(zero_w), .dump(ifb),
    .halted(halted_b), .done(done_b)
  );

  halt_dump_ctrl #(.DRAIN_CYCLES(10), .NUM_REGS(16), .MEM_DEPTH(4), .SKIP_ZERO(1'b0)) dut_c (
    .clk(clk), .reset(reset_s), .instr(instr_s), .reg_rd_idx(ridx_c), .reg_rd_data(rdata_c),
    .mem_rd_en(mem_en_c), .mem_rd_addr(maddr_c), .mem_rd_data(zero_w), .dump(ifc),
    .halted(halted_c), .done(done_c)
  );

  task automatic test_reset();
    logic [70:0] obs;
    reset_a = 1'b1; instr_a = 16'h1234; ifa.out_ready = 1'b0;
    reset_s = 1'b1; instr_s = 16'h1234; ifb.out_ready = 1'b0; ifc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    obs = {ifa.out_valid, logic'(ifa.out_kind), ifa.out_addr, ifa.out_data, mem_en_a, maddr_a, ridx_a,
           halted_a, done_a};
    n_checks++;
    if (obs !== '0) $display("FAIL reset_a: outputs=%h required 0", obs); else n_pass++;
    n_checks++;
    if ({ifb.out_valid, ifc.out_valid, mem_en_b, mem_en_c, halted_b, halted_c, done_b, done_c} !== 8'h00)
      $display("FAIL reset_bc: valid=%b%b halted=%b%b done=%b%b required 0", ifb.out_valid, ifc.out_valid,
               halted_b, halted_c, done_b, done_c);
    else n_pass++;
    reset_a = 1'b0; reset_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt_timing();
    int first = 0;
    logic mem_seen = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (halted_a !== 1'b0) $display("FAIL not_halted: halted=%b required 0", halted_a); else n_pass++;
    instr_a = HALT_OP_A;
    @(negedge clk);
    instr_a = 16'h1234;
    n_checks++;
    if (halted_a !== 1'b1) $display("FAIL halted_rise: halted=%b required 1", halted_a); else n_pass++;
    for (int n = 1; n <= 20; n++) begin
      if (mem_en_a) mem_seen = 1'b1;
      if (ifa.out_valid === 1'b1) begin
        first = n;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (first != 11) $display("FAIL first_valid: cycle=%0d required 11", first); else n_pass++;
    n_checks++;
    if (mem_seen !== 1'b0) $display("FAIL mem_en_drain: mem_rd_en seen=%b required 0", mem_seen); else n_pass++;
    n_checks++;
    if ({logic'(ifa.out_kind), ifa.out_addr} !== 17'h0)
      $display("FAIL first_rec: kind=%b addr=%h required kind=0 addr=0000", ifa.out_kind, ifa.out_addr);
    else n_pass++;
  endtask

  task automatic test_reg_dump();
    rec_t e;
    rec_t got;
    for (int i = 0; i < 16; i++) sb.push_back(rec_t'{1'b0, 16'(i), 16'hA000 + 16'(i)});
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got = {logic'(ifa.out_kind), ifa.out_addr, ifa.out_data};
      e = sb.pop_front();
      n_checks++;
      if (ifa.out_valid !== 1'b1 || got !== e)
        $display("FAIL reg_rec%0d: valid=%b rec=%h required valid=1 rec=%h", i, ifa.out_valid, got, e);
      else n_pass++;
      @(negedge clk);
    end
    ifa.out_ready = 1'b0;
    n_checks++;
    if ({mem_en_a, maddr_a} !== 17'h1_0000)
      $display("FAIL first_mem_rd: en=%b addr=%h required en=1 addr=0000", mem_en_a, maddr_a);
    else n_pass++;
  endtask

  task automatic test_mem_skip();
    rec_t e;
    rec_t got;
    logic started = 1'b0, wrapped = 1'b0, bp_bad = 1'b0, bp_done = 1'b0, timeout = 1'b1;
    word_t prev = '0;
    sb.push_back(rec_t'{1'b1, 16'd5, 16'h00FF});
    sb.push_back(rec_t'{1'b1, LAST_A, 16'hBEEF});
    for (int c = 0; c < 3 * DEPTH_A + 200; c++) begin
      if (done_a === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      if (mem_en_a) begin
        if (started && maddr_a <= prev) wrapped = 1'b1;
        prev = maddr_a;
        started = 1'b1;
      end
      if (ifa.out_valid === 1'b1) begin
        got = {logic'(ifa.out_kind), ifa.out_addr, ifa.out_data};
        if (!bp_done && got.addr == 16'd5) begin
          for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (ifa.out_valid !== 1'b1 || mem_en_a !== 1'b0 ||
                {logic'(ifa.out_kind), ifa.out_addr, ifa.out_data} !== got) bp_bad = 1'b1;
          end
          bp_done = 1'b1;
          n_checks++;
          if (bp_bad) $display("FAIL backpressure_hold: unstable=%b required 0", bp_bad); else n_pass++;
        end
        ifa.out_ready = 1'b1;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL mem_extra: rec=%h required none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) $display("FAIL mem_rec: rec=%h required %h", got, e); else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (timeout) $display("FAIL mem_timeout: done=%b required 1", done_a); else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL mem_missing: left=%0d required 0", sb.size()); else n_pass++;
    n_checks++;
    if (wrapped || !bp_done) $display("FAIL mem_order: wrapped=%b bp_seen=%b required 0/1", wrapped, bp_done);
    else n_pass++;
    n_checks++;
    if ({done_a, ifa.out_valid, mem_en_a} !== 3'b100)
      $display("FAIL done_state: done/valid/en=%b required 100", {done_a, ifa.out_valid, mem_en_a});
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_done_sticky();
    instr_a = HALT_OP_A;
    @(negedge clk);
    instr_a = 16'h1234;
    repeat (15) @(negedge clk);
    n_checks++;
    if ({done_a, halted_a, ifa.out_valid, mem_en_a} !== 4'b1100)
      $display("FAIL done_sticky: done/halted/valid/en=%b required 1100", {done_a, halted_a, ifa.out_valid, mem_en_a});
    else n_pass++;
  endtask

  task automatic test_reset_mid_dump();
    logic hit = 1'b0;
    logic [70:0] obs;
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    instr_a = HALT_OP_B;
    @(negedge clk);
    instr_a = 16'h1234;
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (mem_en_a === 1'b1 && maddr_a == 16'd100) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) $display("FAIL reach_addr100: reached=%b required 1", hit); else n_pass++;
    reset_a = 1'b1;
    @(negedge clk);
    obs = {ifa.out_valid, logic'(ifa.out_kind), ifa.out_addr, ifa.out_data, mem_en_a, maddr_a, ridx_a,
           halted_a, done_a};
    n_checks++;
    if (obs !== '0) $display("FAIL reset_mid: outputs=%h required 0", obs); else n_pass++;
    reset_a = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({halted_a, ifa.out_valid, mem_en_a} !== 3'b000)
      $display("FAIL no_resume: halted/valid/en=%b required 000", {halted_a, ifa.out_valid, mem_en_a});
    else n_pass++;
  endtask

  task automatic test_restart();
    rec_t e;
    rec_t got;
    int first = 0;
    logic timeout = 1'b1;
    for (int i = 0; i < 16; i++) sb.push_back(rec_t'{1'b0, 16'(i), 16'hA000 + 16'(i)});
    sb.push_back(rec_t'{1'b1, 16'd5, 16'h00FF});
    sb.push_back(rec_t'{1'b1, LAST_A, 16'hBEEF});
    ifa.out_ready = 1'b1;
    instr_a = HALT_OP_A;
    @(negedge clk);
    instr_a = 16'h1234;
    for (int c = 1; c < 3 * DEPTH_A + 200; c++) begin
      if (done_a === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      if (ifa.out_valid === 1'b1) begin
        if (first == 0) first = c;
        got = {logic'(ifa.out_kind), ifa.out_addr, ifa.out_data};
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL restart_extra: rec=%h required none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) $display("FAIL restart_rec: rec=%h required %h", got, e); else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (first != 11) $display("FAIL restart_first: cycle=%0d required 11", first); else n_pass++;
    n_checks++;
    if (timeout || sb.size() != 0)
      $display("FAIL restart_end: timeout=%b left=%0d required 0/0", timeout, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_no_skip();
    rec_t e;
    rec_t got;
    int nb_reg = 0, nb_mem = 0, nc_reg = 0;
    logic timeout = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(rec_t'{1'b1, 16'(i), 16'h0000});
    ifb.out_ready = 1'b1;
    ifc.out_ready = 1'b1;
    instr_s = HALT_OP_A;
    @(negedge clk);
    instr_s = 16'h0000;
    for (int c = 0; c < 300; c++) begin
      if (done_b === 1'b1 && done_c === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      if (ifb.out_valid === 1'b1) begin
        if (ifb.out_kind == DUMP_MEM) nb_mem++; else nb_reg++;
      end
      if (ifc.out_valid === 1'b1) begin
        if (ifc.out_kind == DUMP_REG) begin
          nc_reg++;
        end else begin
          got = {logic'(ifc.out_kind), ifc.out_addr, ifc.out_data};
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL noskip_extra: rec=%h required none", got);
          end else begin
            e = sb.pop_front();
            if (got !== e) $display("FAIL noskip_rec: rec=%h required %h", got, e); else n_pass++;
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (timeout) $display("FAIL small_timeout: done=%b%b required 11", done_b, done_c); else n_pass++;
    n_checks++;
    if (nb_mem != 0 || nb_reg != 16)
      $display("FAIL skip_counts: mem=%0d reg=%0d required 0/16", nb_mem, nb_reg);
    else n_pass++;
    n_checks++;
    if (nc_reg != 16 || sb.size() != 0)
      $display("FAIL noskip_counts: reg=%0d left=%0d required 16/0", nc_reg, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_halt_timing();
    test_reg_dump();
    test_mem_skip();
    test_done_sticky();
    test_reset_mid_dump();
    test_restart();
    test_no_skip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
